spi_reg_bank: RTL

Parametrised SPI slave register bank. It replaces the fixed-output SPI receiver with a generic NUM_REGS × DATA_W control-register file that the external master can write and read back. The block runs in the system `clk` domain and oversamples the SPI pins, so no logic is clocked by SCLK. The demoscene top slices `regs` into its control fields: background state, solid colour, audio enable and the new fields.

---
 rtl/spi_reg_bank.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave exposing a NUM_REGS x DATA_W control-register
// file. Everything runs on clk; the SPI pins are oversampled through 2-flop
// synchronisers, with a third SCLK flop for edge detection.
module spi_reg_bank #(
    parameter int                         NUM_REGS  = 4,
    parameter int                         DATA_W    = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         SSEL,
    input  logic                         MOSI,
    output logic                         MISO,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    output logic                         busy
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int RX_W   = DATA_W - 1;
    localparam logic [3:0]        CMD_LAST  = 4'd7;
    localparam logic [3:0]        WORD_LAST = 4'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                       state_r, state_next_s;
    logic                         sclk_s1_r, sclk_s2_r, sclk_s3_r;
    logic                         ssel_s1_r, ssel_s2_r;
    logic                         mosi_s1_r, mosi_s2_r;
    logic [1:0]                   settle_r;
    logic                         armed_r;
    logic [3:0]                   bit_cnt_r;
    logic [RX_W-1:0]              rx_shift_r;
    logic [DATA_W-1:0]            tx_shift_r;
    logic [ADDR_W-1:0]            addr_r;
    logic                         write_mode_r;
    logic                         miso_r;
    logic [NUM_REGS*DATA_W-1:0]   regs_r;
    logic                         wr_strobe_r;
    logic [ADDR_W-1:0]            wr_addr_r;

    logic                         rise_s, fall_s;
    logic [ADDR_W-1:0]            cmd_addr_s, next_addr_s;
    logic [DATA_W-1:0]            word_s;

    assign rise_s      = sclk_s2_r & ~sclk_s3_r;
    assign fall_s      = ~sclk_s2_r & sclk_s3_r;
    // Command address: upper command bits beyond ADDR_W are deliberately dropped.
    assign cmd_addr_s  = ADDR_W'({rx_shift_r[6:0], mosi_s2_r});
    assign next_addr_s = addr_r + ADDR_ONE;
    assign word_s      = {rx_shift_r, mosi_s2_r};

    assign MISO      = miso_r;
    assign regs      = regs_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign busy      = ssel_s2_r;

    // Pin synchronisers; MOSI shares SCLK's depth so each bit lines up with its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_r <= 1'b0;
            sclk_s2_r <= 1'b0;
            sclk_s3_r <= 1'b0;
            ssel_s1_r <= 1'b0;
            ssel_s2_r <= 1'b0;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
        end else begin
            sclk_s1_r <= SCLK;
            sclk_s2_r <= sclk_s1_r;
            sclk_s3_r <= sclk_s2_r;
            ssel_s1_r <= SSEL;
            ssel_s2_r <= ssel_s1_r;
            mosi_s1_r <= MOSI;
            mosi_s2_r <= mosi_s1_r;
        end
    end

    // Arm frame detection only after SSEL has been seen low once the synchronisers hold real pin values,
    // so a frame already in progress when reset releases is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= 2'b00;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= {settle_r[0], 1'b1};
            if (settle_r[1] && !ssel_s2_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: SSEL low always returns to IDLE, taking priority over bit events.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ssel_s2_r && armed_r) begin
                    state_next_s = ST_CMD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (!ssel_s2_r) begin
                    state_next_s = ST_IDLE;
                end else if (rise_s && (bit_cnt_r == CMD_LAST)) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_CMD;
                end
            end
            ST_DATA: begin
                if (!ssel_s2_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: command decode, word capture/write, and read shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r    <= 4'd0;
            rx_shift_r   <= '0;
            tx_shift_r   <= '0;
            addr_r       <= '0;
            write_mode_r <= 1'b0;
            miso_r       <= 1'b0;
            regs_r       <= RESET_VAL;
            wr_strobe_r  <= 1'b0;
            wr_addr_r    <= '0;
        end else begin
            wr_strobe_r <= 1'b0;
            if (!ssel_s2_r || (state_r == ST_IDLE)) begin
                // Outside a frame (or aborting one): drop any partial word.
                bit_cnt_r    <= 4'd0;
                rx_shift_r   <= '0;
                tx_shift_r   <= '0;
                addr_r       <= '0;
                write_mode_r <= 1'b0;
                miso_r       <= 1'b0;
            end else if (state_r == ST_CMD) begin
                if (rise_s) begin
                    if (bit_cnt_r == CMD_LAST) begin
                        bit_cnt_r    <= 4'd0;
                        rx_shift_r   <= '0;
                        addr_r       <= cmd_addr_s;
                        write_mode_r <= rx_shift_r[6];
                        tx_shift_r   <= regs_r[cmd_addr_s*DATA_W +: DATA_W];
                    end else begin
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                        rx_shift_r <= {rx_shift_r[RX_W-2:0], mosi_s2_r};
                    end
                end
            end else begin
                if (rise_s) begin
                    if (bit_cnt_r == WORD_LAST) begin
                        bit_cnt_r  <= 4'd0;
                        rx_shift_r <= '0;
                        addr_r     <= next_addr_s;
                        if (write_mode_r) begin
                            regs_r[addr_r*DATA_W +: DATA_W] <= word_s;
                            wr_strobe_r <= 1'b1;
                            wr_addr_r   <= addr_r;
                        end else begin
                            // Preload the next word so a burst read continues without a gap.
                            tx_shift_r <= regs_r[next_addr_s*DATA_W +: DATA_W];
                        end
                    end else begin
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                        rx_shift_r <= {rx_shift_r[RX_W-2:0], mosi_s2_r};
                    end
                end else if (fall_s && !write_mode_r) begin
                    miso_r     <= tx_shift_r[DATA_W-1];
                    tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule
